// File: rtl/uart_line_rx.sv
// uart_line_rx: ROT13 undo plus CR/LF collapse into a FWFT FIFO with counted overruns
module uart_line_rx #(
   parameter int DEPTH = 8,
   parameter bit ROT13 = 1'b1,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rcv,
   input  logic [7:0]        data,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, AFTER_CR} state_t;
   state_t state;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] rdPtr, wrPtr;
   logic [AW:0] count;
   logic [7:0] rotByte, pushByte;
   logic pushReq, pop, push, drop;
   always_comb begin
      rotByte = !ROT13 ? data :
                ((data >= 8'h41 && data <= 8'h4D) || (data >= 8'h61 && data <= 8'h6D)) ? data + 8'd13 :
                ((data >= 8'h4E && data <= 8'h5A) || (data >= 8'h6E && data <= 8'h7A)) ? data - 8'd13 : data;
      pushByte = rotByte == 8'h0A ? 8'h0D : rotByte;
      pushReq = rcv && !(state == AFTER_CR && rotByte == 8'h0A);
      pop = out_valid && out_ready;
      push = pushReq && (!count[AW] || pop);
      drop = pushReq && !push;
   end
   assign out_valid = |count;
   assign out_data = mem[rdPtr];
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (rcv) state <= rotByte == 8'h0D ? AFTER_CR : IDLE;
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop) rdPtr <= rdPtr + AW'(1);
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (drop) begin
            overflow <= 1'b1;
            if (!(&drop_cnt)) drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end
   always_ff @(posedge clk) if (push && !rst) mem[wrPtr] <= pushByte;
endmodule
